// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: captures ALU result and control, registers the
// zero and signed-overflow flags, and feeds the MEM-stage forwarding path.
module ex_mem_reg #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic [2:0]       ex_alu_ctrl,
  input  logic             ex_a_msb,
  input  logic             ex_b_msb,
  input  logic [WIDTH-1:0] ex_alu_result,
  input  logic             ex_trap_ovf,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic             ex_mem_to_reg,
  input  logic [REGW-1:0]  ex_write_reg,
  input  logic [WIDTH-1:0] ex_store_data,
  output logic             mem_valid,
  output logic [WIDTH-1:0] mem_alu_result,
  output logic             mem_zero,
  output logic             mem_reg_write,
  output logic             mem_mem_read,
  output logic             mem_mem_write,
  output logic             mem_mem_to_reg,
  output logic [REGW-1:0]  mem_write_reg,
  output logic [WIDTH-1:0] mem_store_data,
  output logic             ovf_exception,
  output logic             ctrl_err,
  output logic             fwd_en,
  output logic [REGW-1:0]  fwd_reg,
  output logic [WIDTH-1:0] fwd_data
);

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic             r_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_reg_write;
  logic             r_mem_read;
  logic             r_mem_write;
  logic             r_mem_to_reg;
  logic [REGW-1:0]  r_write_reg;
  logic [WIDTH-1:0] r_store_data;
  logic             r_ovf_exc;
  logic             r_ctrl_err;

  logic w_res_msb;
  logic w_ovf;
  logic w_undef;
  logic w_live;
  logic w_trap;

  assign w_res_msb = ex_alu_result[WIDTH-1];

  always_comb begin
    w_ovf   = 1'b0;
    w_undef = 1'b0;
    unique case (ex_alu_ctrl)
      ALU_ADD: w_ovf = (ex_a_msb == ex_b_msb) & (w_res_msb != ex_a_msb);
      ALU_SUB: w_ovf = (ex_a_msb != ex_b_msb) & (w_res_msb != ex_a_msb);
      ALU_AND, ALU_OR, ALU_SLT: w_ovf = 1'b0;
      default: w_undef = 1'b1;
    endcase
  end

  // An undefined select turns the slot into a bubble rather than a real op.
  assign w_live = ex_valid & ~w_undef;
  assign w_trap = w_live & ex_trap_ovf & w_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_result     <= '0;
      r_zero       <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_write_reg  <= '0;
      r_store_data <= '0;
      r_ovf_exc    <= 1'b0;
      r_ctrl_err   <= 1'b0;
    end else if (flush) begin
      // Bubble only: data fields and the error flag are left untouched.
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_ovf_exc    <= 1'b0;
    end else if (stall) begin
      r_ovf_exc    <= 1'b0;
    end else begin
      r_valid      <= w_live;
      r_result     <= ex_alu_result;
      r_zero       <= (ex_alu_result == '0);
      r_reg_write  <= w_live & ~w_trap & ex_reg_write;
      r_mem_read   <= w_live & ~w_trap & ex_mem_read;
      r_mem_write  <= w_live & ~w_trap & ex_mem_write;
      r_mem_to_reg <= w_live & ex_mem_to_reg;
      r_write_reg  <= ex_write_reg;
      r_store_data <= ex_store_data;
      r_ovf_exc    <= w_trap;
      r_ctrl_err   <= r_ctrl_err | (ex_valid & w_undef);
    end
  end

  assign mem_valid      = r_valid;
  assign mem_alu_result = r_result;
  assign mem_zero       = r_zero;
  assign mem_reg_write  = r_reg_write;
  assign mem_mem_read   = r_mem_read;
  assign mem_mem_write  = r_mem_write;
  assign mem_mem_to_reg = r_mem_to_reg;
  assign mem_write_reg  = r_write_reg;
  assign mem_store_data = r_store_data;
  assign ovf_exception  = r_ovf_exc;
  assign ctrl_err       = r_ctrl_err;

  assign fwd_en   = r_valid & r_reg_write & ~r_mem_to_reg
                  & (r_write_reg != '0);
  assign fwd_reg  = r_write_reg;
  assign fwd_data = r_result;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed table-driven bench for ex_mem_reg plus a few hand-written
// sequences for sticky error, stall holding and reset-over-stall.
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst, stall, flush, ex_valid;
  logic [2:0]  ex_alu_ctrl;
  logic        ex_a_msb, ex_b_msb;
  logic [31:0] ex_alu_result;
  logic        ex_trap_ovf, ex_reg_write, ex_mem_read;
  logic        ex_mem_write, ex_mem_to_reg;
  logic [4:0]  ex_write_reg;
  logic [31:0] ex_store_data;
  logic        mem_valid;
  logic [31:0] mem_alu_result;
  logic        mem_zero, mem_reg_write, mem_mem_read;
  logic        mem_mem_write, mem_mem_to_reg;
  logic [4:0]  mem_write_reg;
  logic [31:0] mem_store_data;
  logic        ovf_exception, ctrl_err, fwd_en;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_mem_reg #(.WIDTH(32), .REGW(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_alu_ctrl(ex_alu_ctrl),
    .ex_a_msb(ex_a_msb), .ex_b_msb(ex_b_msb),
    .ex_alu_result(ex_alu_result), .ex_trap_ovf(ex_trap_ovf),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_write_reg(ex_write_reg), .ex_store_data(ex_store_data),
    .mem_valid(mem_valid), .mem_alu_result(mem_alu_result),
    .mem_zero(mem_zero), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_write_reg(mem_write_reg),
    .mem_store_data(mem_store_data), .ovf_exception(ovf_exception),
    .ctrl_err(ctrl_err), .fwd_en(fwd_en), .fwd_reg(fwd_reg),
    .fwd_data(fwd_data)
  );

  typedef struct {
    logic        rst, stall, flush, valid;
    logic [2:0]  ctrl;
    logic        amsb, bmsb;
    logic [31:0] res;
    logic        trap, rw, mr, mw, m2r;
    logic [4:0]  wreg;
    logic [31:0] sd;
    logic        e_valid;
    logic [31:0] e_res;
    logic        e_zero, e_rw, e_mr, e_mw, e_m2r;
    logic [4:0]  e_wreg;
    logic [31:0] e_sd;
    logic        e_ovf, e_err, e_fwd;
  } vec_t;

  localparam int NV = 19;
  vec_t v [NV];

  function automatic logic [114:0] pack_act();
    return {mem_valid, mem_alu_result, mem_zero, mem_reg_write,
            mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_write_reg,
            mem_store_data, ovf_exception, ctrl_err, fwd_en,
            fwd_reg, fwd_data};
  endfunction

  function automatic logic [114:0] pack_exp(vec_t x);
    return {x.e_valid, x.e_res, x.e_zero, x.e_rw, x.e_mr, x.e_mw,
            x.e_m2r, x.e_wreg, x.e_sd, x.e_ovf, x.e_err, x.e_fwd,
            x.e_wreg, x.e_res};
  endfunction

  task automatic drive(vec_t x);
    rst = x.rst; stall = x.stall; flush = x.flush;
    ex_valid = x.valid; ex_alu_ctrl = x.ctrl;
    ex_a_msb = x.amsb; ex_b_msb = x.bmsb;
    ex_alu_result = x.res; ex_trap_ovf = x.trap;
    ex_reg_write = x.rw; ex_mem_read = x.mr;
    ex_mem_write = x.mw; ex_mem_to_reg = x.m2r;
    ex_write_reg = x.wreg; ex_store_data = x.sd;
  endtask

  task automatic check1(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  initial begin
    vec_t z;
    vec_t r;
    logic [114:0] a;
    logic [114:0] e;
    z = '{0,0,0,0,3'b000,0,0,32'h0,0,0,0,0,0,5'd0,32'h0,
          0,32'h0,0,0,0,0,0,5'd0,32'h0,0,0,0};
    r = z;
    r.rst = 1'b1;
    drive(z);

    v[0]  = r;
    v[1]  = r;
    v[2]  = '{0,0,0,1,3'b010,0,0,32'h5,1,1,0,0,0,5'd8,32'h11,
              1,32'h5,0,1,0,0,0,5'd8,32'h11,0,0,1};
    v[3]  = '{0,0,0,1,3'b010,0,0,32'h8000_0000,1,1,0,0,0,5'd9,32'h0,
              1,32'h8000_0000,0,0,0,0,0,5'd9,32'h0,1,0,0};
    v[4]  = '{0,0,0,1,3'b010,0,0,32'h8000_0000,0,1,0,0,0,5'd9,32'h0,
              1,32'h8000_0000,0,1,0,0,0,5'd9,32'h0,0,0,1};
    v[5]  = '{0,0,0,1,3'b110,1,1,32'h0,1,1,0,0,0,5'd10,32'h22,
              1,32'h0,1,1,0,0,0,5'd10,32'h22,0,0,1};
    v[6]  = '{0,0,0,1,3'b110,0,1,32'hF000_0000,1,1,0,1,0,5'd11,32'h33,
              1,32'hF000_0000,0,0,0,0,0,5'd11,32'h33,1,0,0};
    v[7]  = '{0,1,0,1,3'b010,0,0,32'h1234,0,1,0,0,0,5'd3,32'h44,
              1,32'hF000_0000,0,0,0,0,0,5'd11,32'h33,0,0,0};
    v[8]  = '{0,1,0,1,3'b010,0,0,32'h0,1,1,1,0,1,5'd4,32'h45,
              1,32'hF000_0000,0,0,0,0,0,5'd11,32'h33,0,0,0};
    v[9]  = '{0,1,0,1,3'b011,0,0,32'h9,0,1,0,0,0,5'd5,32'h46,
              1,32'hF000_0000,0,0,0,0,0,5'd11,32'h33,0,0,0};
    v[10] = '{0,0,0,1,3'b000,1,1,32'h7,1,1,0,0,0,5'd12,32'hABCD,
              1,32'h7,0,1,0,0,0,5'd12,32'hABCD,0,0,1};
    v[11] = '{0,1,1,1,3'b010,0,0,32'h8000_0000,1,1,0,0,0,5'd13,32'h0,
              0,32'h7,0,0,0,0,0,5'd12,32'hABCD,0,0,0};
    v[12] = '{0,0,0,1,3'b010,0,0,32'h100,0,0,0,1,0,5'd0,32'h55,
              1,32'h100,0,0,0,1,0,5'd0,32'h55,0,0,0};
    v[13] = '{0,0,0,1,3'b001,0,0,32'h3,0,1,0,0,0,5'd0,32'h0,
              1,32'h3,0,1,0,0,0,5'd0,32'h0,0,0,0};
    v[14] = '{0,0,0,1,3'b010,0,0,32'h40,1,1,1,0,1,5'd14,32'h0,
              1,32'h40,0,1,1,0,1,5'd14,32'h0,0,0,0};
    v[15] = '{0,0,0,0,3'b010,0,0,32'h99,0,1,0,0,0,5'd5,32'h66,
              0,32'h99,0,0,0,0,0,5'd5,32'h66,0,0,0};
    v[16] = '{0,0,1,1,3'b101,0,0,32'h1,0,1,0,0,0,5'd7,32'h1,
              0,32'h99,0,0,0,0,0,5'd5,32'h66,0,0,0};
    v[17] = '{0,0,0,1,3'b100,0,0,32'h77,0,1,0,0,0,5'd6,32'h88,
              0,32'h77,0,0,0,0,0,5'd6,32'h88,0,1,0};
    v[18] = '{0,0,0,1,3'b111,1,0,32'h1,1,1,0,0,0,5'd2,32'h0,
              1,32'h1,0,1,0,0,0,5'd2,32'h0,0,1,1};

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(v[i]);
      @(posedge clk);
      #1;
      a = pack_act();
      e = pack_exp(v[i]);
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL vec%0d: got %h want %h", i, a, e);
      end
    end

    // Sticky error survives ten bubble cycles.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      drive(z);
      @(posedge clk);
      #1;
      check1($sformatf("err_sticky%0d", k), {31'd0, ctrl_err}, 32'd1);
      check1($sformatf("bubble_valid%0d", k), {31'd0, mem_valid}, 32'd0);
    end

    // Reset asserted during stall still clears everything.
    @(negedge clk);
    drive(r);
    stall = 1'b1;
    @(posedge clk);
    #1;
    a = pack_act();
    e = pack_exp(r);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL rst_stall: got %h want %h", a, e);
    end
    @(negedge clk);
    drive(z);
    stall = 1'b1;
    @(posedge clk);
    #1;
    check1("err_after_rst", {31'd0, ctrl_err}, 32'd0);
    check1("fwd_after_rst", {31'd0, fwd_en}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- EX/MEM pipeline register for the pipelined MIPS core, directly downstream of the bit-sliced ALU result select.
- Captures the 32-bit ALU result plus EX-stage control.
- Computes the registered zero and signed-overflow flags.
- Applies stall and flush, and drives the forwarding path back into EX.

Parameters:
- WIDTH, 32: datapath width of the ALU result and store data.
- REGW, 5: register-file index width.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- stall  input  1  hold all registered state this cycle.
- flush  input  1  replace the incoming instruction with a bubble.
- ex_valid  input  1  EX slot holds a real instruction.
- ex_alu_ctrl  input  3  ALU select: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- ex_a_msb  input  1  bit WIDTH-1 of operand A.
- ex_b_msb  input  1  bit WIDTH-1 of operand B.
- ex_alu_result  input  WIDTH  ALU output.
- ex_trap_ovf  input  1  signed op (add/sub/addi); trap on overflow.
- ex_reg_write  input  1  write-back enable.
- ex_mem_read  input  1  load.
- ex_mem_write  input  1  store.
- ex_mem_to_reg  input  1  write-back selects memory data.
- ex_write_reg  input  REGW  destination register.
- ex_store_data  input  WIDTH  rt value for stores.
- mem_valid  output  1  MEM slot holds a real instruction.
- mem_alu_result  output  WIDTH  registered ALU result, used as address or write-back data.
- mem_zero  output  1  registered result == 0.
- mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg  output  1 each  registered controls.
- mem_write_reg  output  REGW  registered destination register.
- mem_store_data  output  WIDTH  registered store data.
- ovf_exception  output  1  one-cycle pulse: the MEM-slot instruction overflowed.
- ctrl_err  output  1  sticky: an undefined ALU select was seen on a valid instruction.
- fwd_en  output  1  forward enable = mem_valid & mem_reg_write & ~mem_mem_to_reg & (mem_write_reg != 0).
- fwd_reg  output  REGW  equals mem_write_reg.
- fwd_data  output  WIDTH  equals mem_alu_result.

Behaviour:
- Reset:
  - Synchronous reset, active-high, on clk rising edge.
  - All mem_* outputs, ovf_exception and ctrl_err are 0.
  - fwd_en is therefore 0.
- Priority on each rising edge: rst > flush > stall > load.
- Load:
  - Latency 1 cycle; every ex_* input appears on its mem_* counterpart at the next edge.
  - mem_zero is registered from ex_alu_result == 0, so it is valid in the same cycle as mem_alu_result.
- Overflow detect, evaluated on EX inputs:
  - ADD: ovf = (a_msb == b_msb) & (result_msb != a_msb).
  - SUB: ovf = (a_msb != b_msb) & (result_msb != a_msb).
  - All other selects: ovf = 0.
  - If ex_valid & ex_trap_ovf & ovf:
    - mem_reg_write, mem_mem_read and mem_mem_write load 0.
    - mem_valid loads 1.
    - ovf_exception is 1 for exactly one cycle.
  - Unsigned ops (ex_trap_ovf = 0) never trap; wrap-around results pass unchanged.
- Undefined select (011, 100, 101) with ex_valid = 1:
  - Loads a bubble: mem_valid and all controls 0; data fields don't-care but deterministic (load them anyway).
  - ctrl_err sets and stays set until rst.
  - The previous result is never held in its place.
- Bubble (ex_valid = 0): mem_valid = 0 and all enables 0; data fields load normally.
- Stall:
  - All registers hold.
  - ovf_exception drops to 0 after its pulse; it never re-pulses while stalled.
  - The fwd_* outputs stay driven from the held values.
- Flush:
  - Loads a bubble (valid and controls 0).
  - Overrides stall.
  - Suppresses ovf_exception and any ctrl_err set for that instruction.
- Simultaneous flush with an overflowing input: no exception and no state change beyond the bubble.
- Reset mid-stall: reset wins; the next cycle shows the reset state regardless of stall.
- fwd_en is combinational from the registered outputs; there is no extra latency.

Test Plan:
- Reset then load of an ADD: rst high 2 cycles; then ex_valid = 1, ctrl = 010, result = 0x0000_0005, reg_write = 1, write_reg = 8 -> next cycle mem_valid = 1, mem_alu_result = 5, mem_zero = 0, fwd_en = 1, fwd_reg = 8.
- Signed overflow:
  - ADD, a_msb = 0, b_msb = 0, result = 0x8000_0000, trap_ovf = 1 -> mem_reg_write = 0, ovf_exception pulses 1 cycle.
  - Same stimulus with trap_ovf = 0 -> mem_reg_write = 1, no pulse.
- SUB zero: ctrl = 110, result = 0 -> mem_zero = 1.
- Stall and flush:
  - stall = 1 for 3 cycles while the inputs change -> outputs frozen.
  - flush = 1 together with stall = 1 -> mem_valid = 0 and fwd_en = 0 next cycle.
- Undefined select: ctrl = 100, ex_valid = 1 -> mem_valid = 0, ctrl_err = 1, still 1 after 10 further cycles; cleared only by rst.
- Forward suppression:
  - write_reg = 0 with reg_write = 1 -> fwd_en = 0.
  - Load (mem_to_reg = 1) -> fwd_en = 0.
